// File: rtl/dm_responder.sv
// Single-port memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then returns a one-cycle ack with load data or an error flag.
module dm_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept, go_resp;

    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic        be_ok;
    logic        in_range;
    logic        cur_err;
    logic [IDX_W-1:0] cur_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // go_resp marks the edge that enters RESP: the commit point for stores and load data.
    always_comb begin
        state_next = state;
        count_next = count;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself, so the
    // live inputs must be used instead of the not-yet-latched copies.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_be    = be_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_be    = be;
            cur_wdata = wdata;
        end
    end

    always_comb begin
        be_ok = 1'b0;
        case (cur_be)
            4'b0001: be_ok = (cur_addr[1:0] == 2'd0);
            4'b0010: be_ok = (cur_addr[1:0] == 2'd1);
            4'b0100: be_ok = (cur_addr[1:0] == 2'd2);
            4'b1000: be_ok = (cur_addr[1:0] == 2'd3);
            4'b0011: be_ok = (cur_addr[1:0] == 2'd0);
            4'b1100: be_ok = (cur_addr[1:0] == 2'd2);
            4'b1111: be_ok = (cur_addr[1:0] == 2'd0);
            default: be_ok = 1'b0;
        endcase
    end

    assign in_range = ({2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS));
    assign cur_err  = !be_ok || !in_range;
    assign cur_idx  = cur_addr[IDX_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                be_q    <= be;
                wdata_q <= wdata;
            end
            if (go_resp) begin
                err_q   <= cur_err;
                rdata_q <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Storage has no reset; the reset gate only blocks a zero-wait commit while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign ready = (state == IDLE);
    assign ack   = (state == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
